gun_hit_detector: RTL and testbench

//  Light-gun front end sitting directly upstream of the target-drawing VGA stage.
//  - Synchronises and debounces the raw trigger.
//  - Issues a frame-aligned shot_fired pulse; that stage answers it by drawing the white target box.
//  - Watches the photodiode while the box is on screen and decides hit or miss.
//  - Drives duck_hit back to that stage and to game logic; score logic takes shot_miss.

---
 rtl/gun_hit_detector.sv | 197 +++++++++++++++++++
 tb/tb_gun_hit_detector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gun_hit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : gun_hit_detector
// Description : Light-gun front end. Synchronises and debounces the trigger,
//               issues a frame-aligned shot_fired pulse, watches the
//               photodiode while the target box is shown and reports a hit
//               (duck_hit level) or a miss (shot_miss pulse).
// Revision    : 1.0 - initial release
// ============================================================================
module gun_hit_detector #(
    parameter int unsigned DEBOUNCE_CYCLES  = 65000,
    parameter int unsigned SETTLE_FRAMES    = 1,
    parameter int unsigned WINDOW_FRAMES    = 3,
    parameter int unsigned LIGHT_MIN_CYCLES = 2000,
    parameter int unsigned TARGET_FRAMES    = 60
) (
    input  logic clk,
    input  logic rst,               // asynchronous, active low
    input  logic trigger_raw,
    input  logic sensor_raw,
    input  logic new_frame,
    input  logic gun_is_connected,
    output logic shot_fired,
    output logic duck_hit,
    output logic shot_miss,
    output logic busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LC_W = $clog2(LIGHT_MIN_CYCLES + 1);
    localparam int FC_W = $clog2(TARGET_FRAMES + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LC_W-1:0] LC_LAST    = LC_W'(LIGHT_MIN_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_SETTLE  = FC_W'(SETTLE_FRAMES);
    localparam logic [FC_W-1:0] FC_TIMEOUT = FC_W'(SETTLE_FRAMES + WINDOW_FRAMES);
    localparam logic [FC_W-1:0] FC_TARGET  = FC_W'(TARGET_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SYNC   = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    logic            trig_meta_q, trig_sync_q;
    logic            sens_meta_q, sens_sync_q;
    logic [DB_W-1:0] db_cnt_q;
    logic            trig_db_q, trig_db_prev_q;
    logic            shot_req;

    state_t          state_q, state_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
    logic [LC_W-1:0] light_cnt_q, light_cnt_d;
    logic            duck_hit_q, duck_hit_d;

    // Two-flop synchronisers for the asynchronous trigger and photodiode inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            sens_meta_q <= 1'b0;
            sens_sync_q <= 1'b0;
        end else begin
            trig_meta_q <= trigger_raw;
            trig_sync_q <= trig_meta_q;
            sens_meta_q <= sensor_raw;
            sens_sync_q <= sens_meta_q;
        end
    end

    // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt_q       <= '0;
            trig_db_q      <= 1'b0;
            trig_db_prev_q <= 1'b0;
        end else begin
            trig_db_prev_q <= trig_db_q;
            if (trig_sync_q == trig_db_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                db_cnt_q  <= '0;
                trig_db_q <= ~trig_db_q;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign shot_req  = trig_db_q & ~trig_db_prev_q;
    assign frame_inc = (frame_cnt_q == '1) ? frame_cnt_q : frame_cnt_q + 1'b1;

    // FSM state and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            light_cnt_q <= '0;
            duck_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            light_cnt_q <= light_cnt_d;
            duck_hit_q  <= duck_hit_d;
        end
    end

    // Next-state logic; a lost gun connection overrides every other decision
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        light_cnt_d = light_cnt_q;
        duck_hit_d  = duck_hit_q;
        shot_fired  = 1'b0;
        shot_miss   = 1'b0;

        if ((state_q != S_IDLE) && !gun_is_connected) begin
            state_d     = S_IDLE;
            frame_cnt_d = '0;
            light_cnt_d = '0;
            duck_hit_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_cnt_d = '0;
                    light_cnt_d = '0;
                    duck_hit_d  = 1'b0;
                    if (shot_req && gun_is_connected) begin
                        state_d = S_SYNC;
                    end
                end
                S_SYNC: begin
                    // The target box is drawn starting with this frame
                    if (new_frame) begin
                        shot_fired  = 1'b1;
                        frame_cnt_d = '0;
                        state_d     = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    // Sensor deliberately ignored while display and diode catch up
                    if (new_frame) begin
                        frame_cnt_d = frame_inc;
                    end
                    if (frame_cnt_d >= FC_SETTLE) begin
                        state_d = S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (new_frame) begin
                        frame_cnt_d = frame_inc;
                    end
                    if (sens_sync_q) begin
                        light_cnt_d = (light_cnt_q == LC_LAST) ? light_cnt_q : light_cnt_q + 1'b1;
                    end else begin
                        light_cnt_d = '0;
                    end
                    // A hit takes precedence over a window timeout in the same cycle
                    if (sens_sync_q && (light_cnt_q == LC_LAST)) begin
                        duck_hit_d  = 1'b1;
                        light_cnt_d = '0;
                        state_d     = S_HOLD;
                    end else if (new_frame && (frame_cnt_d >= FC_TIMEOUT)) begin
                        shot_miss   = 1'b1;
                        light_cnt_d = '0;
                        state_d     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Blocks new shots until the target has been on screen its full time
                    if (new_frame) begin
                        frame_cnt_d = frame_inc;
                    end
                    if (frame_cnt_d >= FC_TARGET) begin
                        state_d     = S_IDLE;
                        frame_cnt_d = '0;
                        duck_hit_d  = 1'b0;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    frame_cnt_d = '0;
                    light_cnt_d = '0;
                    duck_hit_d  = 1'b0;
                end
            endcase
        end
    end

    assign duck_hit = duck_hit_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gun_hit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_gun_hit_detector
// Description : Self-checking bench for gun_hit_detector. Expected events
//               (shot, hit, miss, hit release, return to idle) are queued
//               with their cycle numbers and matched against DUT activity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gun_hit_detector;

    localparam int FRAME = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trigger_raw = 1'b0;
    logic sensor_raw = 1'b0;
    logic new_frame = 1'b0;
    logic gun_is_connected = 1'b1;
    logic shot_fired, duck_hit, shot_miss, busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {EV_SHOT, EV_HIT, EV_MISS, EV_DROP, EV_IDLE} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;
    ev_t exp_q[$];

    typedef struct {
        string tag;
        int    off;     // first sensor-high cycle, relative to the shot cycle
        int    hi1;
        int    lo;
        int    hi2;
        bit    hit;
        int    ev_rel;  // cycle of duck_hit rise (hit) relative to the shot cycle
    } vec_t;
    vec_t tbl[8];

    gun_hit_detector #(
        .DEBOUNCE_CYCLES  (4),
        .SETTLE_FRAMES    (1),
        .WINDOW_FRAMES    (2),
        .LIGHT_MIN_CYCLES (8),
        .TARGET_FRAMES    (6)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .trigger_raw      (trigger_raw),
        .sensor_raw       (sensor_raw),
        .new_frame        (new_frame),
        .gun_is_connected (gun_is_connected),
        .shot_fired       (shot_fired),
        .duck_hit         (duck_hit),
        .shot_miss        (shot_miss),
        .busy             (busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame pulse in every cycle whose index is a multiple of FRAME
    initial forever begin
        @(posedge clk);
        #1;
        new_frame = ((cyc % FRAME) == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic got(input ev_kind_t k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s at cycle %0d, expected none", k.name(), cyc);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != k) || (e.cyc != cyc)) begin
                n_bad++;
                $display("FAIL event: got %s at cycle %0d, expected %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Event monitor, sampled on the falling edge
    logic dh_prev = 1'b0;
    logic busy_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (shot_fired === 1'b1)                 got(EV_SHOT);
        if (duck_hit === 1'b1 && !dh_prev)       got(EV_HIT);
        if (shot_miss === 1'b1)                  got(EV_MISS);
        if (duck_hit === 1'b0 && dh_prev)        got(EV_DROP);
        if (busy === 1'b0 && busy_prev)          got(EV_IDLE);
        dh_prev   = (duck_hit === 1'b1);
        busy_prev = (busy === 1'b1);
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Move to tick 20 of a frame; the shot then lands on the next frame start
    task automatic align(output int b);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % FRAME) != 20);
        b = cyc + 80;
    endtask

    task automatic pull_trigger(input int n);
        int e;
        e = cyc + n;
        trigger_raw = 1'b1;
        wait_cyc(e);
        trigger_raw = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int b;
        align(b);
        push_ev(EV_SHOT, b);
        if (v.hit) push_ev(EV_HIT, b + v.ev_rel);
        else       push_ev(EV_MISS, b + 300);
        if (v.hit) push_ev(EV_DROP, b + 601);
        push_ev(EV_IDLE, b + 601);
        pull_trigger(12);
        wait_cyc(b + v.off);
        sensor_raw = 1'b1;
        wait_cyc(b + v.off + v.hi1);
        sensor_raw = 1'b0;
        if (v.hi2 > 0) begin
            wait_cyc(b + v.off + v.hi1 + v.lo);
            sensor_raw = 1'b1;
            wait_cyc(b + v.off + v.hi1 + v.lo + v.hi2);
            sensor_raw = 1'b0;
        end
        wait_cyc(b + 500);
        check({v.tag, "_busy_in_hold"}, busy, 1);
        check({v.tag, "_duck_hit_in_hold"}, duck_hit, v.hit);
        wait_cyc(b + 610);
    endtask

    initial begin
        int b;
        tbl[0] = '{"hit_10",      110, 10, 0, 0, 1'b1, 120};
        tbl[1] = '{"gap_7_1_7",   110,  7, 1, 7, 1'b0,   0};
        tbl[2] = '{"hit_exact_8", 110,  8, 0, 0, 1'b1, 120};
        tbl[3] = '{"short_7",     110,  7, 0, 0, 1'b0,   0};
        tbl[4] = '{"settle_only",  20, 50, 0, 0, 1'b0,   0};
        tbl[5] = '{"straddle",     95, 10, 0, 0, 1'b0,   0};
        tbl[6] = '{"frame2_hit",  195, 10, 0, 0, 1'b1, 205};
        tbl[7] = '{"hit_vs_tmo",  291,  8, 0, 0, 1'b1, 301};

        #2 rst = 1'b0;
        #16;
        check("reset_shot_fired", shot_fired, 0);
        check("reset_duck_hit",   duck_hit,   0);
        check("reset_shot_miss",  shot_miss,  0);
        check("reset_busy",       busy,       0);
        wait_cyc(3);
        rst = 1'b1;

        // Bouncy trigger gives one shot; a re-trigger during HOLD is dropped
        align(b);
        push_ev(EV_SHOT, b);
        push_ev(EV_MISS, b + 300);
        push_ev(EV_IDLE, b + 601);
        trigger_raw = 1'b1; wait_cyc(cyc + 2);
        trigger_raw = 1'b0; wait_cyc(cyc + 2);
        pull_trigger(30);
        wait_cyc(b + 350);
        pull_trigger(12);
        wait_cyc(b + 610);

        // Trigger with the gun unplugged is ignored
        gun_is_connected = 1'b0;
        pull_trigger(12);
        wait_cyc(cyc + 150);
        check("unplugged_busy", busy, 0);
        gun_is_connected = 1'b1;
        wait_cyc(cyc + 50);

        // Unplug during SAMPLE: back to IDLE next cycle, no miss
        align(b);
        push_ev(EV_SHOT, b);
        push_ev(EV_IDLE, b + 251);
        pull_trigger(12);
        wait_cyc(b + 250);
        gun_is_connected = 1'b0;
        wait_cyc(b + 251);
        check("abort_sample_busy", busy, 0);
        gun_is_connected = 1'b1;
        wait_cyc(b + 450);

        // Unplug while a hit is being held: duck_hit drops with the abort
        align(b);
        push_ev(EV_SHOT, b);
        push_ev(EV_HIT,  b + 120);
        push_ev(EV_DROP, b + 151);
        push_ev(EV_IDLE, b + 151);
        pull_trigger(12);
        wait_cyc(b + 110);
        sensor_raw = 1'b1;
        wait_cyc(b + 120);
        sensor_raw = 1'b0;
        wait_cyc(b + 150);
        gun_is_connected = 1'b0;
        wait_cyc(b + 151);
        check("abort_hold_duck_hit", duck_hit, 0);
        gun_is_connected = 1'b1;
        wait_cyc(b + 450);

        for (int i = 0; i < 8; i++) begin
            run_vec(tbl[i]);
        end

        // Asynchronous reset while duck_hit is high
        align(b);
        push_ev(EV_SHOT, b);
        push_ev(EV_HIT,  b + 120);
        push_ev(EV_DROP, b + 150);
        push_ev(EV_IDLE, b + 150);
        pull_trigger(12);
        wait_cyc(b + 110);
        sensor_raw = 1'b1;
        wait_cyc(b + 120);
        sensor_raw = 1'b0;
        wait_cyc(b + 150);
        #1 rst = 1'b0;
        #1;
        check("async_rst_duck_hit",   duck_hit,   0);
        check("async_rst_busy",       busy,       0);
        check("async_rst_shot_miss",  shot_miss,  0);
        check("async_rst_shot_fired", shot_fired, 0);
        @(posedge clk);
        #1;
        wait_cyc(b + 153);
        rst = 1'b1;
        wait_cyc(b + 160);
        check("post_rst_busy", busy, 0);
        run_vec(tbl[0]);

        wait_cyc(cyc + 20);
        check("pending_events", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected end before it", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
